// File: rtl/versatile_fifo_rd_ctrl.sv
// Read-side engine of the single-clock versatile FIFO: walks rd_ptr through RAM port B,
// absorbs the registered read latency and presents a 2-entry first-word-fall-through stream.
module versatile_fifo_rd_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH:0]   wr_ptr,
   input  logic                  flush,
   output logic [ADDR_WIDTH-1:0] ram_adr,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic [ADDR_WIDTH:0]   rd_ptr,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  empty,
   output logic [ADDR_WIDTH+1:0] level
);

   localparam int unsigned PW = ADDR_WIDTH + 1;
   localparam int unsigned LW = ADDR_WIDTH + 2;

   logic                  inflight;
   logic [1:0]            occ;
   logic [DATA_WIDTH-1:0] buf1;

   logic [PW-1:0]         rd_ptr_nx;
   logic                  inflight_nx;
   logic [1:0]            occ_nx;
   logic [1:0]            occ_after_pop;
   logic [DATA_WIDTH-1:0] buf0_nx;
   logic [DATA_WIDTH-1:0] buf1_nx;
   logic                  dout_valid_nx;
   logic                  avail;
   logic                  pop;
   logic                  issue;

   assign avail         = (wr_ptr != rd_ptr);
   assign pop           = dout_valid & dout_ready;
   assign occ_after_pop = occ - 2'(pop);
   // Only issue if the word can land: buffered + in-flight words after this pop must stay < 2.
   assign issue         = avail & ~flush & ((3'(occ) + 3'(inflight) - 3'(pop)) < 3'd2);

   // Next-state for pointer, pipeline flag and the 2-entry output buffer.
   always_comb begin
      rd_ptr_nx     = rd_ptr;
      inflight_nx   = inflight;
      occ_nx        = occ;
      buf0_nx       = dout;
      buf1_nx       = buf1;
      dout_valid_nx = dout_valid;
      if (flush) begin
         rd_ptr_nx     = wr_ptr;
         inflight_nx   = 1'b0;
         occ_nx        = 2'd0;
         dout_valid_nx = 1'b0;
      end else begin
         if (issue) begin
            rd_ptr_nx = rd_ptr + PW'(1);
         end
         inflight_nx = issue;
         if (pop && (occ == 2'd2)) begin
            buf0_nx = buf1;
         end
         if (inflight) begin
            if (occ_after_pop == 2'd0) begin
               buf0_nx = ram_q;
            end else begin
               buf1_nx = ram_q;
            end
         end
         occ_nx        = occ_after_pop + 2'(inflight);
         dout_valid_nx = (occ_nx != 2'd0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr     <= '0;
         inflight   <= 1'b0;
         occ        <= 2'd0;
         dout       <= '0;
         buf1       <= '0;
         dout_valid <= 1'b0;
      end else begin
         rd_ptr     <= rd_ptr_nx;
         inflight   <= inflight_nx;
         occ        <= occ_nx;
         dout       <= buf0_nx;
         buf1       <= buf1_nx;
         dout_valid <= dout_valid_nx;
      end
   end

   assign ram_adr = rd_ptr[ADDR_WIDTH-1:0];
   assign empty   = ~avail & ~inflight & (occ == 2'd0);
   assign level   = LW'(PW'(wr_ptr - rd_ptr)) + LW'(inflight) + LW'(occ);

endmodule
